// File: rtl/uart_tx_arbiter.sv
// Two-source byte arbiter feeding a UART transmitter: keyboard and VT100 reply FIFOs.
// Define UART_TX_RR_EN for round-robin arbitration; default is fixed reply-first priority.
module uart_tx_arbiter #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyValid,
    input  logic [7:0] keyData,
    output logic       keyFull,
    input  logic       replyValid,
    input  logic [7:0] replyData,
    output logic       replyFull,
    output logic       txStart,
    output logic [7:0] txData,
    input  logic       txBusy,
    output logic       activeSource,
    output logic [7:0] dropCount
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(ACK_TIMEOUT - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_ACK  = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    // Index 0 is the keyboard FIFO, index 1 the reply FIFO.
    logic [7:0]    mem_q    [2][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [CW-1:0] cnt_q    [2];
    logic [7:0]    push_data[2];
    logic [7:0]    head     [2];
    logic [1:0]    push_valid, push_ok, pop, full, nonempty, drop;

    logic [1:0] state_q, state_d;
    logic       src_q, src_d;
    logic [7:0] data_q, data_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] drop_q, drop_d;
    logic [8:0] drop_sum;
    logic       sel;

    assign push_valid   = {replyValid, keyValid};
    assign push_data[0] = keyData;
    assign push_data[1] = replyData;

    // A pop in the same cycle frees the slot, so a push to a full FIFO then still lands.
    always_comb begin
        pop = '0;
        if (state_q == WAIT_ACK && txBusy) begin
            pop[src_q] = 1'b1;
        end
        for (int unsigned s = 0; s < 2; s++) begin
            full[s]     = (cnt_q[s] == DEPTH_C);
            nonempty[s] = (cnt_q[s] != '0);
            head[s]     = mem_q[s][rd_ptr_q[s]];
            push_ok[s]  = push_valid[s] && (!full[s] || pop[s]);
            drop[s]     = push_valid[s] && full[s] && !pop[s];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < 2; s++) begin
            if (push_ok[s]) begin
                mem_q[s][wr_ptr_q[s]] <= push_data[s];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (push_ok[s]) wr_ptr_q[s] <= wr_ptr_q[s] + AW'(1);
                if (pop[s])     rd_ptr_q[s] <= rd_ptr_q[s] + AW'(1);
                cnt_q[s] <= cnt_q[s] + CW'(push_ok[s]) - CW'(pop[s]);
            end
        end
    end

`ifdef UART_TX_RR_EN
    // last_q remembers the source of the last popped byte; reset value favours reply first.
    logic last_q;

    assign sel = (nonempty == 2'b11) ? ~last_q : nonempty[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (pop != '0) begin
            last_q <= src_q;
        end
    end
`else
    assign sel = nonempty[1];
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if ((nonempty != '0) && !txBusy) begin
                    src_d   = sel;
                    data_d  = head[sel];
                    state_d = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (txBusy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                if (!txBusy) state_d = IDLE;
            end
        endcase
    end

    assign drop_sum = {1'b0, drop_q} + 9'(drop[0]) + 9'(drop[1]);
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
        end
    end

    assign txStart      = (state_q == START);
    assign txData       = data_q;
    assign activeSource = src_q;
    assign dropCount    = drop_q;
    assign keyFull      = full[0];
    assign replyFull    = full[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple txBusy responder.
// Expected order for the dual-source test follows UART_TX_RR_EN.
module tb_uart_tx_arbiter;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       keyValid = 1'b0;
    logic [7:0] keyData = '0;
    logic       replyValid = 1'b0;
    logic [7:0] replyData = '0;
    logic       txBusy = 1'b0;
    logic       keyFull, replyFull, txStart, activeSource;
    logic [7:0] txData, dropCount;

    uart_tx_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keyValid    (keyValid),
        .keyData     (keyData),
        .keyFull     (keyFull),
        .replyValid  (replyValid),
        .replyData   (replyData),
        .replyFull   (replyFull),
        .txStart     (txStart),
        .txData      (txData),
        .txBusy      (txBusy),
        .activeSource(activeSource),
        .dropCount   (dropCount)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    logic [7:0]  log_data[$];
    logic        log_src[$];
    int unsigned log_cyc[$];

    // busy_mode: 0 = hold low, 1 = hold high, 2 = respond to txStart with 4 busy cycles
    int          busy_mode = 0;
    int unsigned busy_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (txStart) begin
            log_data.push_back(txData);
            log_src.push_back(activeSource);
            log_cyc.push_back(cyc);
        end
        if (busy_mode == 2) begin
            if (txStart) busy_left = 4;
            txBusy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end else begin
            busy_left = 0;
            txBusy    = (busy_mode == 1);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input logic kv, input logic [7:0] kd, input logic rv, input logic [7:0] rd);
        @(negedge clk);
        keyValid = kv; keyData = kd; replyValid = rv; replyData = rd;
        @(negedge clk);
        keyValid = 1'b0; replyValid = 1'b0;
    endtask

    task automatic set_busy(input int m);
        @(posedge clk);
        busy_mode = m;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_src.delete();
        log_cyc.delete();
    endtask

    task automatic wait_log(input string tag, input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (log_data.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check_eq(tag, 32'(log_data.size() >= n), 32'd1);
    endtask

    logic [7:0] exp_order[4];
    logic       exp_src[4];
    logic       full_seen;

    initial begin
`ifdef UART_TX_RR_EN
        exp_order = '{8'h1B, 8'h61, 8'h5B, 8'h62};
        exp_src   = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{8'h1B, 8'h5B, 8'h61, 8'h62};
        exp_src   = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_txStart", 32'(txStart), 32'd0);
        check_eq("rst_txData", 32'(txData), 32'h0);
        check_eq("rst_src", 32'(activeSource), 32'd0);
        check_eq("rst_drop", 32'(dropCount), 32'd0);
        check_eq("rst_keyFull", 32'(keyFull), 32'd0);
        check_eq("rst_replyFull", 32'(replyFull), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single keyboard byte: latency and one start
        set_busy(2);
        @(negedge clk);
        keyValid = 1'b1; keyData = 8'h41;
        @(negedge clk);
        keyValid = 1'b0;
        check_eq("lat_no_start_yet", 32'(txStart), 32'd0);
        @(negedge clk);
        check_eq("lat_start", 32'(txStart), 32'd1);
        check_eq("lat_data", 32'(txData), 32'h41);
        check_eq("lat_src", 32'(activeSource), 32'd0);
        full_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (keyFull) full_seen = 1'b1;
        end
        check_eq("one_keyFull_seen", 32'(full_seen), 32'd0);
        check_eq("one_start_count", 32'(log_data.size()), 32'd1);
        check_eq("one_data_hold", 32'(txData), 32'h41);

        // Simultaneous pushes from both sources
        clear_log();
        drive(1'b1, 8'h61, 1'b1, 8'h1B);
        drive(1'b1, 8'h62, 1'b1, 8'h5B);
        wait_log("arb_four_sent", 4, 100);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("arb_data%0d", i), 32'(log_data[i]), 32'(exp_order[i]));
            check_eq($sformatf("arb_src%0d", i), 32'(log_src[i]), 32'(exp_src[i]));
        end
        check_eq("arb_b2b_spacing", log_cyc[1] - log_cyc[0], 32'd6);

        // Overfill keyboard FIFO while the transmitter is busy
        set_busy(1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0, 8'h00);
            if (i == 6) check_eq("fill_not_full_7", 32'(keyFull), 32'd0);
            if (i == 7) check_eq("fill_full_8", 32'(keyFull), 32'd1);
        end
        check_eq("fill_drop2", 32'(dropCount), 32'd2);
        check_eq("fill_replyFull", 32'(replyFull), 32'd0);
        clear_log();
        set_busy(2);
        wait_log("drain_eight", 8, 150);
        check_eq("drain_first", 32'(log_data[0]), 32'h30);
        check_eq("drain_last", 32'(log_data[7]), 32'h37);
        repeat (20) @(posedge clk);
        check_eq("drain_count", 32'(log_data.size()), 32'd8);
        check_eq("drain_keyFull", 32'(keyFull), 32'd0);

        // Ack timeout and retry
        clear_log();
        set_busy(0);
        drive(1'b1, 8'h0D, 1'b0, 8'h00);
        wait_log("tmo_three", 3, 100);
        check_eq("tmo_period1", log_cyc[1] - log_cyc[0], 32'(TMO + 2));
        check_eq("tmo_period2", log_cyc[2] - log_cyc[1], 32'(TMO + 2));
        check_eq("tmo_data", 32'(log_data[2]), 32'h0D);
        set_busy(2);
        wait_log("tmo_acked", 4, 60);
        check_eq("tmo_ack_data", 32'(log_data[3]), 32'h0D);
        repeat (60) @(posedge clk);
        check_eq("tmo_popped_once", 32'(log_data.size()), 32'd4);

        // Reset during WAIT_DONE with three bytes queued
        clear_log();
        set_busy(1);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h71 + i), 1'b0, 8'h00);
        set_busy(2);
        wait_log("mid_first_start", 1, 20);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_txStart", 32'(txStart), 32'd0);
        check_eq("mid_rst_txData", 32'(txData), 32'h0);
        check_eq("mid_rst_src", 32'(activeSource), 32'd0);
        check_eq("mid_rst_drop", 32'(dropCount), 32'd0);
        check_eq("mid_rst_keyFull", 32'(keyFull), 32'd0);
        check_eq("mid_rst_replyFull", 32'(replyFull), 32'd0);
        set_busy(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        check_eq("mid_no_restart", 32'(log_data.size()), 32'd1);
        set_busy(2);
        drive(1'b1, 8'h55, 1'b0, 8'h00);
        wait_log("mid_new_push", 2, 20);
        check_eq("mid_new_data", 32'(log_data[1]), 32'h55);
        repeat (30) @(posedge clk);
        check_eq("mid_fifo_empty", 32'(log_data.size()), 32'd2);

        // Push into a full FIFO on the pop cycle, then saturate dropCount
        clear_log();
        set_busy(1);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 8'h00);
        check_eq("sat_keyFull", 32'(keyFull), 32'd1);
        check_eq("sat_drop0", 32'(dropCount), 32'd0);
        set_busy(2);
        wait_log("pop_start", 1, 20);
        @(negedge clk);
        keyValid = 1'b1; keyData = 8'hAA;
        @(negedge clk);
        keyValid = 1'b0;
        check_eq("pop_push_no_drop", 32'(dropCount), 32'd0);
        check_eq("pop_push_full", 32'(keyFull), 32'd1);
        set_busy(1);
        for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b1, 8'(8'h90 + i));
        check_eq("sat_replyFull", 32'(replyFull), 32'd1);
        drive(1'b1, 8'h01, 1'b1, 8'h02);
        check_eq("sat_double_drop", 32'(dropCount), 32'd2);
        for (int i = 0; i < 126; i++) drive(1'b1, 8'h01, 1'b1, 8'h02);
        check_eq("sat_254", 32'(dropCount), 32'd254);
        drive(1'b1, 8'h01, 1'b1, 8'h02);
        check_eq("sat_double_clip", 32'(dropCount), 32'd255);
        drive(1'b1, 8'h01, 1'b0, 8'h00);
        check_eq("sat_hold", 32'(dropCount), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, meaning: entries per requester FIFO; SHALL be a power of two, 2..64.
REQ-002 Parameter ACK_TIMEOUT, default 15, meaning: cycles to wait for txBusy after txStart; range 1..255.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 keyValid  in  1  one-cycle pulse; keyboard ASCII byte present.
REQ-006 keyData  in  8  keyboard byte.
REQ-007 keyFull  out  1  keyboard FIFO full.
REQ-008 replyValid  in  1  one-cycle pulse; VT100 parser reply byte present, e.g. a DSR/DA answer.
REQ-009 replyData  in  8  reply byte.
REQ-010 replyFull  out  1  reply FIFO full.
REQ-011 txStart  out  1  one-cycle start strobe to the UART transmitter.
REQ-012 txData  out  8  byte to transmit; valid while txStart=1.
REQ-013 txBusy  in  1  transmitter busy flag.
REQ-014 activeSource  out  1  0=keyboard, 1=reply; source of the byte in flight.
REQ-015 dropCount  out  8  saturating count of bytes dropped on full FIFOs.

Function
REQ-016 Each requester SHALL have its own FIFO of FIFO_DEPTH bytes; a valid pulse pushes one byte with no handshake back to the producer.
REQ-017 A push to a full FIFO SHALL be discarded and SHALL increment dropCount; dropCount saturates at 255.
REQ-018 A push to a full FIFO in the same cycle as a pop from that FIFO SHALL be accepted and SHALL NOT count as a drop.
REQ-019 Simultaneous keyValid and replyValid SHALL both be accepted when there is space; a double drop SHALL add 2 to dropCount, saturating.
REQ-020 The FSM SHALL have exactly four states: IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-021 IDLE: if any FIFO is non-empty and txBusy=0, select a source per REQ-027/028, latch its head byte into txData, set activeSource, and go to START.
REQ-022 START: assert txStart for exactly one cycle and go to WAIT_ACK; first txStart SHALL appear 2 cycles after a push to an empty, idle block.
REQ-023 WAIT_ACK: on txBusy=1, pop the selected FIFO and go to WAIT_DONE.
REQ-023a WAIT_ACK timeout: if txBusy stays 0 for ACK_TIMEOUT cycles, go to IDLE without popping, and the same byte SHALL be retried.
REQ-024 WAIT_DONE: on txBusy=0, go to IDLE; back-to-back bytes SHALL have at most 2 idle cycles between txBusy falling and the next txStart.
REQ-025 txData and activeSource SHALL hold stable from START through WAIT_DONE.
REQ-026 keyFull and replyFull SHALL reflect the registered occupancy; they SHALL NOT depend combinationally on the push inputs.

Configuration
REQ-027 With UART_TX_RR_EN defined, arbitration SHALL be round-robin: when both FIFOs are non-empty, the source not served last wins; after reset, reply is preferred first.
REQ-028 Without UART_TX_RR_EN, arbitration SHALL use fixed priority: reply always wins over keyboard when both are non-empty.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE and both FIFOs SHALL be empty.
REQ-030 While rst=1, the outputs SHALL be: txStart=0, txData=0, activeSource=0, dropCount=0, keyFull=0, replyFull=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the byte in flight without popping it or recording it; after release, the block SHALL start from IDLE.

Verification
REQ-032 Push keyData=0x41 with txBusy modelled as high 1 cycle after start for 20 cycles: expect txData=0x41 and activeSource=0, keyFull=0 throughout, and exactly one txStart.
REQ-033 Push keyboard 0x61,0x62 and reply 0x1B,0x5B in the same cycles: with UART_TX_RR_EN expect order 1B,61,5B,62; without it expect 1B,5B,61,62.
REQ-034 Push 10 keyboard bytes with txBusy held 1 and FIFO_DEPTH=8: expect keyFull=1 after byte 8 and dropCount=2.
REQ-035 Tie txBusy=0, push 0x0D: expect txStart every ACK_TIMEOUT+2 cycles with txData=0x0D; after releasing the busy model, expect one pop and the FIFO empty.
REQ-036 Assert rst during WAIT_DONE with 3 bytes queued: expect all outputs at reset values, and no txStart after release until a new push.
REQ-037 Hold dropCount=255, then push to a full FIFO: expect dropCount to remain 255.
